alu_writeback_stage: RTL and testbench

Registered stage directly downstream of the ALU. It captures the ALU result (Y) and flag outputs (N, Z, CO, OVF) through a valid/ready handshake and holds the architectural status register (CPSR, NZCV). It gates each operation on an ARM-style condition code evaluated against the committed CPSR, and buffers accepted results in a 2-entry FIFO toward register-file writeback.

---
 rtl/alu_writeback_stage_pkg.sv | 30 +++
 rtl/alu_writeback_stage_cond_eval.sv | 43 ++++
 rtl/alu_writeback_stage.sv | 124 ++++++++++++
 tb/tb_alu_writeback_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_writeback_stage_pkg.sv
// Shared constants for the ALU writeback stage and later branch logic:
// ARM-style condition codes, CPSR flag bit positions and the ALU op class bit.
package alu_writeback_stage_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    // Bit positions inside the 4-bit CPSR {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // ALUcontrol bit that separates logic ops (1) from arithmetic ops (0)
    localparam int ALU_LOGIC_BIT = 2;

endpackage

// File: rtl/alu_writeback_stage_cond_eval.sv
// Combinational ARM condition-code evaluator: decides whether an op with the
// given condition executes against the supplied NZCV flags.
module cond_eval
    import alu_writeback_stage_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic fn;
    logic fz;
    logic fc;
    logic fv;

    assign fn = flags[FLAG_N];
    assign fz = flags[FLAG_Z];
    assign fc = flags[FLAG_C];
    assign fv = flags[FLAG_V];

    // Decode the condition; code F has no special meaning here and behaves as AL
    always_comb begin
        pass = 1'b1;
        case (cond)
            COND_EQ: pass = fz;
            COND_NE: pass = !fz;
            COND_CS: pass = fc;
            COND_CC: pass = !fc;
            COND_MI: pass = fn;
            COND_PL: pass = !fn;
            COND_VS: pass = fv;
            COND_VC: pass = !fv;
            COND_HI: pass = fc && !fz;
            COND_LS: pass = !fc || fz;
            COND_GE: pass = (fn == fv);
            COND_LT: pass = (fn != fv);
            COND_GT: pass = !fz && (fn == fv);
            COND_LE: pass = fz || (fn != fv);
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Registered stage after the ALU: accepts results through valid/ready, gates
// them on the condition code against the committed CPSR, updates NZCV, counts
// skipped ops and queues passing results in a 2-entry FIFO for writeback.
module alu_writeback_stage
    import alu_writeback_stage_pkg::*;
#(
    parameter int W  = 8,
    parameter int RA = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    ALUcontrol,
    input  logic [W-1:0]  Y,
    input  logic          N,
    input  logic          Z,
    input  logic          CO,
    input  logic          OVF,
    input  logic          set_flags,
    input  logic [3:0]    cond,
    input  logic [RA-1:0] dest,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [RA-1:0] out_dest,
    output logic [3:0]    flags,
    output logic          cond_pass,
    output logic [7:0]    skip_cnt
);

    // FIFO is kept as a shift pair: slot 0 is always the head, slot 1 the tail
    logic [1:0]    count;
    logic [W-1:0]  data0;
    logic [W-1:0]  data1;
    logic [RA-1:0] dest0;
    logic [RA-1:0] dest1;
    logic [3:0]    cpsr;
    logic [7:0]    skips;

    logic accept;
    logic push;
    logic pop;

    cond_eval u_cond_eval (
        .cond  (cond),
        .flags (cpsr),
        .pass  (cond_pass)
    );

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && cond_pass;
    assign pop       = out_valid && out_ready;

    assign out_data  = data0;
    assign out_dest  = dest0;
    assign flags     = cpsr;
    assign skip_cnt  = skips;

    // FIFO storage and occupancy; a lone pop leaves the head registers untouched
    // so out_data keeps showing the last result once the FIFO runs empty
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            data0 <= '0;
            data1 <= '0;
            dest0 <= '0;
            dest1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        data0 <= Y;
                        dest0 <= dest;
                    end else begin
                        data1 <= Y;
                        dest1 <= dest;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        data0 <= data1;
                        dest0 <= dest1;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Push only happens below full, so count is 1 here
                    data0 <= Y;
                    dest0 <= dest;
                end
                default: begin
                end
            endcase
        end
    end

    // CPSR update: logic ops carry no meaningful C/V, so those bits hold
    always_ff @(posedge clk) begin
        if (rst) begin
            cpsr <= 4'b0000;
        end else if (push && set_flags) begin
            cpsr[FLAG_N] <= N;
            cpsr[FLAG_Z] <= Z;
            if (!ALUcontrol[ALU_LOGIC_BIT]) begin
                cpsr[FLAG_C] <= CO;
                cpsr[FLAG_V] <= OVF;
            end
        end
    end

    // Saturating count of accepted ops whose condition failed
    always_ff @(posedge clk) begin
        if (rst) begin
            skips <= 8'd0;
        end else if (accept && !cond_pass && (skips != 8'hFF)) begin
            skips <= skips + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_alu_writeback_stage;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] ALUcontrol;
    logic [7:0] Y;
    logic       N;
    logic       Z;
    logic       CO;
    logic       OVF;
    logic       set_flags;
    logic [3:0] cond;
    logic [3:0] dest;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_dest;
    logic [3:0] flags;
    logic       cond_pass;
    logic [7:0] skip_cnt;

    int compared;
    int mismatched;

    // Reference model state
    logic [7:0] m_data[$];
    logic [3:0] m_dest[$];
    logic [3:0] m_flags;
    int         m_skip;
    logic [7:0] m_last_data;
    logic [3:0] m_last_dest;

    alu_writeback_stage #(.W(8), .RA(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUcontrol (ALUcontrol),
        .Y          (Y),
        .N          (N),
        .Z          (Z),
        .CO         (CO),
        .OVF        (OVF),
        .set_flags  (set_flags),
        .cond       (cond),
        .dest       (dest),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_dest   (out_dest),
        .flags      (flags),
        .cond_pass  (cond_pass),
        .skip_cnt   (skip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Conditions come in complementary pairs: bit 0 inverts the base test
    function automatic logic refCond(input logic [3:0] c, input logic [3:0] f);
        logic fn;
        logic fz;
        logic fc;
        logic fv;
        logic base;
        fn = f[3];
        fz = f[2];
        fc = f[1];
        fv = f[0];
        case (c[3:1])
            3'd0: base = fz;
            3'd1: base = fc;
            3'd2: base = fn;
            3'd3: base = fv;
            3'd4: base = fc & ~fz;
            3'd5: base = ~(fn ^ fv);
            3'd6: base = ~fz & ~(fn ^ fv);
            default: return 1'b1;
        endcase
        return c[0] ? ~base : base;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_data.delete();
        m_dest.delete();
        m_flags     = 4'b0000;
        m_skip      = 0;
        m_last_data = 8'h00;
        m_last_dest = 4'h0;
    endtask

    // One clock cycle: drive inputs, check combinational outputs before the
    // edge, advance the model at the edge, then check registered outputs
    task automatic applyStimulus(input logic v, input logic [2:0] ac, input logic [7:0] y,
                                 input logic [3:0] nzcv, input logic sf, input logic [3:0] c,
                                 input logic [3:0] d, input logic ordy, input logic r);
        logic exp_ready;
        logic exp_pass;
        logic exp_pop;
        logic exp_acc;
        logic [7:0] exp_data;
        logic [3:0] exp_dest;
        in_valid   = v;
        ALUcontrol = ac;
        Y          = y;
        N          = nzcv[3];
        Z          = nzcv[2];
        CO         = nzcv[1];
        OVF        = nzcv[0];
        set_flags  = sf;
        cond       = c;
        dest       = d;
        out_ready  = ordy;
        rst        = r;
        @(negedge clk);
        exp_ready = (m_data.size() < 2);
        exp_pass  = refCond(c, m_flags);
        checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
        checkOutput("cond_pass", 32'(cond_pass), 32'(exp_pass));
        @(posedge clk);
        if (r) begin
            modelReset();
        end else begin
            exp_pop = (m_data.size() != 0) && ordy;
            exp_acc = v && exp_ready;
            if (exp_pop) begin
                m_last_data = m_data.pop_front();
                m_last_dest = m_dest.pop_front();
            end
            if (exp_acc) begin
                if (exp_pass) begin
                    m_data.push_back(y);
                    m_dest.push_back(d);
                    if (sf) begin
                        m_flags[3] = nzcv[3];
                        m_flags[2] = nzcv[2];
                        if (!ac[2]) begin
                            m_flags[1:0] = nzcv[1:0];
                        end
                    end
                end else if (m_skip < 255) begin
                    m_skip++;
                end
            end
        end
        #1;
        exp_data = (m_data.size() != 0) ? m_data[0] : m_last_data;
        exp_dest = (m_dest.size() != 0) ? m_dest[0] : m_last_dest;
        checkOutput("out_valid", 32'(out_valid), 32'(m_data.size() != 0));
        checkOutput("out_data", 32'(out_data), 32'(exp_data));
        checkOutput("out_dest", 32'(out_dest), 32'(exp_dest));
        checkOutput("flags", 32'(flags), 32'(m_flags));
        checkOutput("skip_cnt", 32'(skip_cnt), 32'(m_skip));
    endtask

    initial begin
        logic [31:0] rnd;
        compared   = 0;
        mismatched = 0;
        in_valid   = 1'b0;
        ALUcontrol = 3'b000;
        Y          = 8'h00;
        N          = 1'b0;
        Z          = 1'b0;
        CO         = 1'b0;
        OVF        = 1'b0;
        set_flags  = 1'b0;
        cond       = 4'hE;
        dest       = 4'h0;
        out_ready  = 1'b0;
        rst        = 1'b1;
        modelReset();
        @(posedge clk);
        #1;

        // Reset held two cycles with a valid op presented
        applyStimulus(1'b1, 3'b000, 8'hAA, 4'b1111, 1'b1, 4'hE, 4'h1, 1'b0, 1'b1);
        applyStimulus(1'b1, 3'b000, 8'hAA, 4'b1111, 1'b1, 4'hE, 4'h1, 1'b0, 1'b1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_flags", 32'(flags), 32'd0);
        checkOutput("rst_skip", 32'(skip_cnt), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        // Arithmetic op sets Z and C
        applyStimulus(1'b1, 3'b000, 8'h00, 4'b0110, 1'b1, 4'hE, 4'h3, 1'b0, 1'b0);
        checkOutput("arith_data", 32'(out_data), 32'h00);
        checkOutput("arith_dest", 32'(out_dest), 32'h3);
        checkOutput("arith_valid", 32'(out_valid), 32'd1);
        checkOutput("arith_flags", 32'(flags), 32'b0110);

        // Arithmetic op giving flags 0111, popping the previous head
        applyStimulus(1'b1, 3'b001, 8'h00, 4'b0111, 1'b1, 4'hE, 4'h4, 1'b1, 1'b0);
        checkOutput("arith2_flags", 32'(flags), 32'b0111);
        checkOutput("arith2_dest", 32'(out_dest), 32'h4);

        // Logic op keeps C and V
        applyStimulus(1'b1, 3'b100, 8'h80, 4'b1000, 1'b1, 4'hE, 4'h5, 1'b1, 1'b0);
        checkOutput("logic_flags", 32'(flags), 32'b1011);
        checkOutput("logic_data", 32'(out_data), 32'h80);

        // EQ fails with Z clear: nothing pushed, skip counted
        applyStimulus(1'b1, 3'b000, 8'h55, 4'b0100, 1'b1, 4'h0, 4'h6, 1'b1, 1'b0);
        checkOutput("condfail_skip", 32'(skip_cnt), 32'd1);
        checkOutput("condfail_flags", 32'(flags), 32'b1011);
        checkOutput("condfail_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 3'b000, 8'h66, 4'b0000, 1'b0, 4'h1, 4'h7, 1'b1, 1'b0);
        checkOutput("ne_data", 32'(out_data), 32'h66);
        checkOutput("ne_valid", 32'(out_valid), 32'd1);

        // Drain; empty FIFO holds last data even with out_ready high
        applyStimulus(1'b0, 3'b000, 8'h00, 4'b0000, 1'b0, 4'hE, 4'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'b000, 8'h00, 4'b0000, 1'b0, 4'hE, 4'h0, 1'b1, 1'b0);
        checkOutput("empty_hold", 32'(out_data), 32'h66);
        checkOutput("empty_valid", 32'(out_valid), 32'd0);

        // Backpressure: A1, A2 fill the FIFO, a failing op while full is ignored
        applyStimulus(1'b1, 3'b000, 8'hA1, 4'b0000, 1'b0, 4'hE, 4'h1, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'b000, 8'hA2, 4'b0000, 1'b0, 4'hE, 4'h2, 1'b0, 1'b0);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 3'b000, 8'h77, 4'b0000, 1'b0, 4'h0, 4'h9, 1'b0, 1'b0);
        checkOutput("full_skip", 32'(skip_cnt), 32'd1);
        applyStimulus(1'b1, 3'b000, 8'hA3, 4'b0000, 1'b0, 4'hE, 4'h3, 1'b0, 1'b0);
        checkOutput("bp_head_a1", 32'(out_data), 32'hA1);
        applyStimulus(1'b1, 3'b000, 8'hA3, 4'b0000, 1'b0, 4'hE, 4'h3, 1'b1, 1'b0);
        checkOutput("bp_head_a2", 32'(out_data), 32'hA2);
        checkOutput("bp_ready_back", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 3'b000, 8'hA3, 4'b0000, 1'b0, 4'hE, 4'h3, 1'b1, 1'b0);
        checkOutput("bp_head_a3", 32'(out_data), 32'hA3);
        checkOutput("bp_dest_a3", 32'(out_dest), 32'h3);
        applyStimulus(1'b0, 3'b000, 8'h00, 4'b0000, 1'b0, 4'hE, 4'h0, 1'b1, 1'b0);
        checkOutput("bp_drained", 32'(out_valid), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rnd = $urandom();
            applyStimulus(rnd[0], rnd[3:1], rnd[11:4], rnd[15:12], rnd[16],
                          rnd[20:17], rnd[24:21], (rnd[26:25] != 2'b00),
                          ($urandom_range(0, 39) == 0));
        end

        // Mid-operation reset flushes a full FIFO and clears the CPSR
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 3'b000, 8'h00, 4'b0000, 1'b0, 4'hE, 4'h0, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 3'b000, 8'h11, 4'b1111, 1'b1, 4'hE, 4'h7, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'b000, 8'h22, 4'b1101, 1'b1, 4'hE, 4'h8, 1'b0, 1'b0);
        checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
        applyStimulus(1'b1, 3'b000, 8'h33, 4'b1111, 1'b1, 4'hE, 4'h9, 1'b1, 1'b1);
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_flags", 32'(flags), 32'd0);
        checkOutput("midrst_skip", 32'(skip_cnt), 32'd0);

        // Saturation: 300 EQ ops with Z clear
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 3'b000, 8'h5A, 4'b0000, 1'b1, 4'h0, 4'h2, 1'b1, 1'b0);
        end
        checkOutput("sat_skip", 32'(skip_cnt), 32'd255);
        checkOutput("sat_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
